// File: rtl/serializer_if.sv
// Parallel-request / serial-output bundle of the serializer.
// The master drives the parallel request and the slave (the serializer) drives the serial bit stream.
interface serializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ser_data_o, ser_data_val_o, busy_o
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends N bits MSB first with a per-bit valid strobe (N=0 selects DATA_W).
// Defining SERIALIZER_PARITY_EN appends an even-parity bit after the data bits of every word.
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic         clk_i,
  input  logic         srst_i,
  serializer_if.slave  bus
);

  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(3);
  localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [MOD_W:0]    cnt;
  logic              ser_q;
  logic              val_q;
  logic              busy_q;
`ifdef SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  logic [MOD_W:0] req_len;
  logic           accept;

  assign req_len = (bus.data_mod_i == '0) ? FULL_LEN : {1'b0, bus.data_mod_i};
  // Lengths 1 and 2 are dropped silently; the FSM never leaves IDLE for them.
  assign accept  = bus.data_val_i && (state == IDLE) && (req_len >= MIN_LEN);

  // NOTE: every register in this block is updated with <= so all state
  // advances together on the clock edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      ser_q  <= 1'b0;
      val_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The MSB goes straight to the output register, so cnt holds the bits still to come.
            shreg  <= {bus.data_i[DATA_W-2:0], 1'b0};
            cnt    <= req_len - ONE;
            ser_q  <= bus.data_i[DATA_W-1];
            val_q  <= 1'b1;
            busy_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            par_q  <= bus.data_i[DATA_W-1];
`endif
            state  <= SHIFT;
          end else begin
            ser_q  <= 1'b0;
            val_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
            ser_q  <= par_q;
            val_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= PARITY;
`else
            ser_q  <= 1'b0;
            val_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
`endif
          end else begin
            ser_q  <= shreg[DATA_W-1];
            val_q  <= 1'b1;
            busy_q <= 1'b1;
            shreg  <= {shreg[DATA_W-2:0], 1'b0};
            cnt    <= cnt - ONE;
`ifdef SERIALIZER_PARITY_EN
            par_q  <= par_q ^ shreg[DATA_W-1];
`endif
          end
        end

`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          ser_q  <= 1'b0;
          val_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
`endif

        default: begin
          ser_q  <= 1'b0;
          val_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ser_data_o     = ser_q;
  assign bus.ser_data_val_o = val_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter; the transmit-side counterpart of the 16-bit deserializer.
- Accepts one parallel word with a bit count and shifts it out MSB first, one bit per clock, with a per-bit valid strobe.
- Its serial output connects directly to the deserializer's data_i/data_val_i for loopback and link tests.

Parameters:
- DATA_W, 16, parallel word width; must be a power of two, at least 4.
- MOD_W, $clog2(DATA_W), width of the bit-count input.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_W  parallel word to transmit.
- data_mod_i  input  MOD_W  number of bits to send; 0 means DATA_W.
- data_val_i  input  1  data_i/data_mod_i valid; sampled only when busy_o is 0.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o is valid this cycle.
- busy_o  output  1  transmission in progress; new requests are ignored.

Behaviour:
- Clock and reset: one clock clk_i; reset srst_i is synchronous and active-high.
- Reset values: ser_data_o=0, ser_data_val_o=0, busy_o=0, FSM=IDLE, shift register and counters cleared. All outputs are registered.
- FSM states: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- IDLE, accept condition: data_val_i=1 and busy_o=0.
  - Effective length N = data_mod_i, or DATA_W when data_mod_i=0.
  - If N is 1 or 2: the request is dropped, no output, the FSM stays in IDLE.
  - Otherwise: capture data_i into the shift register, capture N, go to SHIFT.
- Latency: the first bit (data_i[DATA_W-1]) appears on ser_data_o the cycle after acceptance, with ser_data_val_o=1.
- SHIFT: emits bits data_i[DATA_W-1] down to data_i[DATA_W-N], one per cycle, N cycles in total.
  - ser_data_val_o=1 and busy_o=1 on every emitted bit.
  - After bit N the FSM returns to IDLE (or goes to PARITY when the feature is enabled).
- busy_o is high exactly during cycles with ser_data_val_o=1. It is low in the cycle after the last bit.
- Back-to-back: the earliest next acceptance is the cycle after the last bit. This leaves one idle cycle (ser_data_val_o=0) between words.
- data_val_i while busy_o=1 is ignored; it is not queued. data_i and data_mod_i may change freely after acceptance.
- Whenever ser_data_val_o=0, ser_data_o is driven 0.
- Reset mid-transmission: in the cycle after srst_i is sampled high, all outputs are 0 and the word is discarded. No partial resume.
- Reset has priority over data_val_i in the same cycle.
- Bit counter: MOD_W+1 bits wide, so N=DATA_W does not wrap.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle.
  - It emits the even-parity bit (XOR of the N transmitted bits) with ser_data_val_o=1 and busy_o=1.
  - It then returns to IDLE.
  - Each word occupies N+1 output cycles.
- Undefined: the PARITY state and XOR accumulator are not compiled; behaviour is exactly as above.

Test Plan:
- Full word: data_i=16'hA5F0, data_mod_i=0, data_val_i one cycle.
  - Expect 16 valid bits 1010_0101_1111_0000, starting 1 cycle after acceptance, with busy_o high for 16 cycles.
  - Looped into the deserializer, this yields deser_data_o=16'hA5F0.
- Partial word: data_i=16'hC000, data_mod_i=3.
  - Expect valid bits 1,1,0, then ser_data_val_o=0 and busy_o=0 on the 4th cycle.
- Illegal lengths: data_mod_i=1 and then 2, with data_val_i pulsed.
  - Expect ser_data_val_o and busy_o to stay 0.
  - An immediate next request with data_mod_i=4 is accepted normally.
- Ignore while busy: start 16'hFFFF with data_mod_i=0, then pulse data_val_i with 16'h0000 at bit 5.
  - Expect 16 ones and no zeros transmitted.
  - Next request accepted only after busy_o falls; 1 gap cycle.
- Reset mid-word: assert srst_i at bit 7 of 16'h1234.
  - Expect all outputs 0 the next cycle.
  - A following 16'h00FF, mod 0 request is transmitted correctly from its first bit.
- With SERIALIZER_PARITY_EN: data_i=16'h7000, data_mod_i=4.
  - Expect bits 0,1,1,1 then parity bit 1; ser_data_val_o high for 5 cycles.
